// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode tracker. Decodes make, break (F0) and extended (E0)
// sequences from the PS/2 byte stream. Keeps a held bitmap of the ten game
// keys and emits one-cycle press and event pulses.
module ps2_key_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned CNT_W          = 22
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_data_en,
    output logic [9:0] key_held,
    output logic [9:0] key_press,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break
);

    typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       held_d, press_d, mask;
    logic             evt_valid_d, evt_ext_d, evt_break_d;
    logic [7:0]       evt_code_d;
    logic             done, done_ext, done_brk, is_prefix, is_ignored;

    // Bitmap index for a final scancode; ext and non-ext namespaces differ.
    function automatic logic [9:0] key_map(input logic [7:0] code, input logic ext);
        logic [9:0] m;
        m = '0;
        if (ext) begin
            case (code)
                8'h75:   m[5] = 1'b1;
                8'h6B:   m[6] = 1'b1;
                8'h72:   m[7] = 1'b1;
                8'h74:   m[8] = 1'b1;
                default: m = '0;
            endcase
        end else begin
            case (code)
                8'h1D:   m[0] = 1'b1;
                8'h1C:   m[1] = 1'b1;
                8'h1B:   m[2] = 1'b1;
                8'h23:   m[3] = 1'b1;
                8'h2B:   m[4] = 1'b1;
                8'h29:   m[9] = 1'b1;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    assign is_prefix  = (ps2_data == 8'hE0) || (ps2_data == 8'hF0);
    // Controller responses and the pause prefix carry no key information.
    assign is_ignored = (ps2_data == 8'hE1) || (ps2_data == 8'hAA) || (ps2_data == 8'hFA) ||
                        (ps2_data == 8'hFE) || (ps2_data == 8'hEE) || (ps2_data == 8'h00) ||
                        (ps2_data == 8'hFF);

    // Next-state: sequence FSM, prefix timeout, bitmap and event outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        held_d      = key_held;
        press_d     = '0;
        evt_valid_d = 1'b0;
        evt_code_d  = evt_code;
        evt_ext_d   = evt_ext;
        evt_break_d = evt_break;
        done        = 1'b0;
        done_ext    = 1'b0;
        done_brk    = 1'b0;
        mask        = '0;

        if (ps2_data_en) begin
            cnt_d = '0;
            case (state_q)
                StIdle: begin
                    if (ps2_data == 8'hF0) begin
                        state_d = StBrk;
                    end else if (ps2_data == 8'hE0) begin
                        state_d = StExt;
                    end else if (!is_ignored) begin
                        done = 1'b1;
                    end
                end
                StBrk: begin
                    state_d  = StIdle;
                    done     = !is_prefix;
                    done_brk = 1'b1;
                end
                StExt: begin
                    if (ps2_data == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (ps2_data != 8'hE0) begin
                        state_d  = StIdle;
                        done     = 1'b1;
                        done_ext = 1'b1;
                    end
                end
                StExtBrk: begin
                    state_d  = StIdle;
                    done     = !is_prefix;
                    done_ext = 1'b1;
                    done_brk = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            // Abandon a prefix whose follow-up byte never arrived.
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end

        if (done) begin
            evt_valid_d = 1'b1;
            evt_code_d  = ps2_data;
            evt_ext_d   = done_ext;
            evt_break_d = done_brk;
            mask        = key_map(ps2_data, done_ext);
            if (done_brk) begin
                held_d = key_held & ~mask;
            end else begin
                // Typematic repeats of an already-held key give no press pulse.
                press_d = mask & ~key_held;
                held_d  = key_held | mask;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            key_held  <= '0;
            key_press <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_ext   <= 1'b0;
            evt_break <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_held  <= held_d;
            key_press <= press_d;
            evt_valid <= evt_valid_d;
            evt_code  <= evt_code_d;
            evt_ext   <= evt_ext_d;
            evt_break <= evt_break_d;
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: expected events are queued as the
// completing byte is driven and checked when evt_valid pulses.
module tb_ps2_key_tracker;

    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] ps2_data = '0;
    logic       ps2_data_en = 1'b0;
    logic [9:0] key_held, key_press;
    logic       evt_valid, evt_ext, evt_break;
    logic [7:0] evt_code;

    ps2_key_tracker #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (5)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .ps2_data   (ps2_data),
        .ps2_data_en(ps2_data_en),
        .key_held   (key_held),
        .key_press  (key_press),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [9:0] held;
        logic [9:0] press;
    } evt_t;

    evt_t       exp_q[$];
    logic [9:0] exp_held = '0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference key table: index -> {ext, code}.
    function automatic logic [9:0] ref_mask(input logic [7:0] code, input logic ext);
        logic [7:0] codes [10];
        logic [9:0] m;
        codes = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h29};
        m = '0;
        for (int i = 0; i < 10; i++) begin
            if (codes[i] == code && ext == (i >= 5 && i <= 8)) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
        evt_t       e;
        logic [9:0] m;
        m = ref_mask(code, ext);
        e.code = code;
        e.ext  = ext;
        e.brk  = brk;
        if (brk) begin
            e.press  = '0;
            exp_held = exp_held & ~m;
        end else begin
            e.press  = m & ~exp_held;
            exp_held = exp_held | m;
        end
        e.held = exp_held;
        exp_q.push_back(e);
    endtask

    // Tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        ps2_data    = b;
        ps2_data_en = 1'b1;
        @(posedge clk);
        #1;
        ps2_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_held"}, key_held, 0);
        check_eq({tag, "_press"}, key_press, 0);
        check_eq({tag, "_evt"}, {evt_valid, evt_code, evt_ext, evt_break}, 0);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (evt_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("evt_unexpected", evt_valid, 0);
                end else begin
                    evt_t e;
                    e = exp_q.pop_front();
                    check_eq("evt_code", evt_code, e.code);
                    check_eq("evt_ext", evt_ext, e.ext);
                    check_eq("evt_break", evt_break, e.brk);
                    check_eq("evt_held", key_held, e.held);
                    check_eq("evt_press", key_press, e.press);
                end
            end else begin
                check_eq("press_no_evt", key_press, 0);
            end
        end
    end

    initial begin
        idle(2);
        check_all_zero("reset");
        resetn = 1'b1;
        mon_en = 1'b1;
        idle(2);
        check_all_zero("post_reset");

        // Make then break of W.
        expect_evt(8'h1D, 0, 0); send_byte(8'h1D); idle(2);
        check_eq("w_held", key_held, 10'h001);
        send_byte(8'hF0); expect_evt(8'h1D, 0, 1); send_byte(8'h1D); idle(2);
        check_eq("w_released", key_held, 10'h000);

        // Typematic repeats: one press pulse only.
        for (int i = 0; i < 3; i++) begin
            expect_evt(8'h1D, 0, 0); send_byte(8'h1D); idle(1);
        end
        check_eq("typematic_held", key_held, 10'h001);
        send_byte(8'hF0); expect_evt(8'h1D, 0, 1); send_byte(8'h1D); idle(2);

        // Extended up arrow, its break, and plain keypad 8.
        send_byte(8'hE0); expect_evt(8'h75, 1, 0); send_byte(8'h75); idle(2);
        check_eq("ext_up_held", key_held, 10'h020);
        send_byte(8'hE0); send_byte(8'hF0); expect_evt(8'h75, 1, 1); send_byte(8'h75); idle(2);
        check_eq("ext_up_released", key_held, 10'h000);
        expect_evt(8'h75, 0, 0); send_byte(8'h75); idle(2);
        check_eq("kp8_unmapped", key_held, 10'h000);

        // Timeout boundary: exactly TMO idle cycles drops the F0 prefix.
        send_byte(8'hF0); idle(TMO);
        expect_evt(8'h1C, 0, 0); send_byte(8'h1C); idle(2);
        check_eq("timeout_make", key_held, 10'h002);
        // Short gap keeps the prefix: this is a break.
        send_byte(8'hF0); idle(5);
        expect_evt(8'h1C, 0, 1); send_byte(8'h1C); idle(2);
        check_eq("short_gap_break", key_held, 10'h000);

        // Ignored bytes and a protocol error (E0 inside a break).
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hE1); idle(2);
        check_eq("ignored_held", key_held, 10'h000);
        send_byte(8'hF0); send_byte(8'hE0);
        expect_evt(8'h1B, 0, 0); send_byte(8'h1B); idle(2);
        send_byte(8'hF0); expect_evt(8'h1B, 0, 1); send_byte(8'h1B); idle(2);

        // Repeated E0 stays extended; dropped prefix inside extended break.
        send_byte(8'hE0); send_byte(8'hE0);
        expect_evt(8'h74, 1, 0); send_byte(8'h74); idle(2);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hE0);
        expect_evt(8'h74, 0, 0); send_byte(8'h74); idle(2);
        check_eq("ext_right_held", key_held, 10'h100);
        send_byte(8'hE0); send_byte(8'hF0); expect_evt(8'h74, 1, 1); send_byte(8'h74); idle(2);

        // Back-to-back strobes: W and D down together.
        expect_evt(8'h1D, 0, 0); expect_evt(8'h23, 0, 0);
        ps2_data = 8'h1D; ps2_data_en = 1'b1;
        @(posedge clk); #1;
        ps2_data = 8'h23;
        @(posedge clk); #1;
        ps2_data_en = 1'b0;
        idle(2);
        check_eq("wd_held", key_held, 10'b00_0000_1001);

        // Reset in the middle of an extended sequence.
        expect_evt(8'h29, 0, 0); send_byte(8'h29); idle(2);
        check_eq("space_held", key_held, 10'h209);
        send_byte(8'hE0);
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
        exp_held = '0;
        check_all_zero("mid_reset");
        expect_evt(8'h75, 0, 0); send_byte(8'h75); idle(2);
        check_eq("after_reset_held", key_held, 10'h000);

        idle(3);
        check_eq("pending_evt", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
